fc_input_loader: RTL and testbench
==================================

// Module: fc_input_loader
// PURPOSE
//  Input-feature loader for the FC datapath. When the decoder's fc_lif_start is high, reads fc_cin words
//  from external memory starting at base_addr and writes them into the FC input buffer.
//  Loads in partitions of BUF_DEPTH words and handshakes each full partition with the consumer.
//  Drives fc_done back to the decoder.
// PARAMETERS
//  DW        32  memory / buffer word width
//  BUF_DEPTH 16  input-buffer words per partition (power of 2)
//  BUF_AW     4  log2(BUF_DEPTH)
//  MAX_OUT    4  max outstanding memory read requests (1..15)
// PORTS
//  clk               in   1    clock
//  rst               in   1    synchronous active-high reset
//  fc_rst            in   1    synchronous soft clear; same effect as rst
//  fc_lif_start      in   1    level; held high by decoder until fc_done seen
//  fc_cin            in   12   words to load; sampled at start
//  base_addr         in   27   word address of first input word; sampled at start
//  fc_done           out  1    1-cycle pulse: load complete
//  fc_next_partition out  1    level: partition full, waiting for part_ack
//  part_ack          in   1    consumer drained buffer; 1-cycle pulse
//  busy              out  1    high in any state except IDLE
//  mem_req_valid     out  1    read request valid
//  mem_req_ready     in   1    read request accepted
//  mem_req_addr      out  27   read word address
//  mem_rsp_valid     in   1    read data valid; in-order, always accepted
//  mem_rsp_data      in   DW   read data
//  buf_we            out  1    buffer write enable
//  buf_waddr         out  BUF_AW  buffer write address
//  buf_wdata         out  DW   buffer write data
// BEHAVIOUR
//  Reset (rst or fc_rst): state=IDLE; all counters=0; every output=0. Mid-operation reset aborts the load.
//  No fc_done is issued for an aborted load.
//  States:
//    IDLE: start=1 latches cin/base; cin==0 -> DONE, else -> ISSUE.
//    ISSUE: issue and receive.
//    PART_WAIT: next_partition=1 until part_ack -> ISSUE.
//    DONE: fc_done=1 for one cycle -> RELEASE.
//    RELEASE: wait until start=0 -> IDLE. This prevents a re-trigger on a held level.
//  Latency: start seen in IDLE at cycle T -> mem_req_valid=1 at T+1 (if cin>0); cin==0 -> fc_done at T+1.
//  Request issue (ISSUE only): valid when req_cnt<cin, req_in_part<BUF_DEPTH and outstanding<MAX_OUT.
//    Once valid is high, valid and addr stay stable until the ready handshake.
//    mem_req_addr = base + req_cnt, mod 2^27 (wraps 0x7FFFFFF -> 0).
//  Outstanding counter: +1 on req handshake, -1 on rsp. Both in one cycle -> unchanged.
//    mem_rsp_valid while outstanding==0 is a protocol error: ignored, no write, no count.
//  Responses: registered write. rsp at cycle R -> buf_we=1 at R+1,
//    with buf_waddr=rsp_in_part (0..BUF_DEPTH-1) and buf_wdata=mem_rsp_data.
//    rsp_cnt and rsp_in_part increment at R.
//  Partition end: rsp_in_part hits BUF_DEPTH with rsp_cnt<cin -> PART_WAIT at R+1. Then:
//    req_in_part and rsp_in_part reset to 0; buf_waddr restarts at 0.
//    part_ack in the same cycle as PART_WAIT entry is honoured.
//    part_ack outside PART_WAIT is ignored.
//  Completion: rsp_cnt reaches cin -> DONE at R+1, coincident with the final buf_we. The last partition,
//    even if exactly BUF_DEPTH, raises no fc_next_partition.
//  Counter widths: req_cnt and rsp_cnt 12 bit; outstanding clog2(MAX_OUT+1) bit; no overflow possible.
//  start dropping during ISSUE or PART_WAIT does not abort; only rst and fc_rst abort.
// STRUCTURE
//  LAYER_FC and the shared width constants (27-bit addr, 12-bit channel count) live in the shared
//  defines header. State encodings are localparams.
//  Single module, no sub-module: one FSM, three counters, one write register.
// TESTING
//  1. cin=5, base=0x100, ready=1, rsp latency 3.
//     -> addrs 0x100..0x104; buf_waddr 0..4; one fc_done pulse; fc_next_partition never high.
//  2. cin=0 -> fc_done at T+1; no mem_req_valid; RELEASE holds while start=1.
//  3. cin=40 -> partitions of 16,16,8; fc_next_partition twice; stalls until part_ack; buf_waddr wraps to 0.
//     cin=32 -> exactly one next_partition.
//  4. mem_req_ready random 30%, rsp latency 10.
//     -> outstanding never >4; addr stable while valid&!ready; 40 writes in order.
//  5. base=0x7FFFFFE, cin=4 -> addrs 0x7FFFFFE, 0x7FFFFFF, 0x0000000, 0x0000001.
//  6. rst after 3 of 8 responses -> all outputs 0 next cycle; stray rsp ignored; new start with cin=2 completes normally.

Source files
------------

// File: rtl/fc_input_loader_pkg.sv
// Shared widths and address helper for the FC input loader.
package fc_input_loader_pkg;

  localparam int ADDR_W = 27;
  localparam int CIN_W  = 12;

  // Word address of element 'off' of a load, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] wrapAddr(input logic [ADDR_W-1:0] base,
                                                 input logic [CIN_W-1:0]  off);
    return base + ADDR_W'(off);
  endfunction

endpackage

// File: rtl/fc_input_loader_if.sv
// Memory read port plus input-buffer write port of the FC input loader.
interface fc_input_loader_if #(
  parameter int DW     = 32,
  parameter int BUF_AW = 4
);

  logic                                   mem_req_valid;
  logic                                   mem_req_ready;
  logic [fc_input_loader_pkg::ADDR_W-1:0] mem_req_addr;
  logic                                   mem_rsp_valid;
  logic [DW-1:0]                          mem_rsp_data;
  logic                                   buf_we;
  logic [BUF_AW-1:0]                      buf_waddr;
  logic [DW-1:0]                          buf_wdata;

  modport master (
    output mem_req_valid, mem_req_addr, buf_we, buf_waddr, buf_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, buf_we, buf_waddr, buf_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

endinterface

// File: rtl/fc_input_loader.sv
// Streams fc_cin words from memory into the FC input buffer, one BUF_DEPTH
// partition at a time, handshaking each full partition with the consumer.
module fc_input_loader
  import fc_input_loader_pkg::*;
#(
  parameter int DW        = 32,
  parameter int BUF_DEPTH = 16,
  parameter int BUF_AW    = 4,
  parameter int MAX_OUT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fc_rst,
  input  logic              fc_lif_start,
  input  logic [CIN_W-1:0]  fc_cin,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              fc_done,
  output logic              fc_next_partition,
  input  logic              part_ack,
  output logic              busy,
  fc_input_loader_if.master bus
);

  localparam int OW = $clog2(MAX_OUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_PART_WAIT = 3'd2;
  localparam logic [2:0] S_DONE      = 3'd3;
  localparam logic [2:0] S_RELEASE   = 3'd4;

  localparam logic [BUF_AW:0] DEPTH_C   = (BUF_AW + 1)'(BUF_DEPTH);
  localparam logic [BUF_AW:0] PART_ONE  = (BUF_AW + 1)'(1);
  localparam logic [CIN_W-1:0] CNT_ONE  = CIN_W'(1);
  localparam logic [OW-1:0]   MAX_OUT_C = OW'(MAX_OUT);
  localparam logic [OW-1:0]   OUT_ONE   = OW'(1);

  logic [2:0]        state_q, state_d;
  logic [CIN_W-1:0]  cin_q, cin_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CIN_W-1:0]  req_cnt_q, req_cnt_d;
  logic [CIN_W-1:0]  rsp_cnt_q, rsp_cnt_d;
  logic [BUF_AW:0]   req_part_q, req_part_d;
  logic [BUF_AW:0]   rsp_part_q, rsp_part_d;
  logic [OW-1:0]     out_q, out_d;
  logic              we_q, we_d;
  logic [BUF_AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0]     wdata_q, wdata_d;

  logic              clear;
  logic              req_valid;
  logic              req_hs;
  logic              rsp_acc;
  logic [CIN_W-1:0]  rsp_cnt_inc;
  logic [BUF_AW:0]   rsp_part_inc;

  assign clear = rst | fc_rst;

  // Valid is a pure function of counters that only move on its own handshake
  // or on responses (which only lower outstanding), so it cannot drop early.
  assign req_valid = (state_q == S_ISSUE) && (req_cnt_q < cin_q) &&
                     (req_part_q < DEPTH_C) && (out_q < MAX_OUT_C);
  assign req_hs    = req_valid & bus.mem_req_ready;
  assign rsp_acc   = bus.mem_rsp_valid && (out_q != '0);

  assign rsp_cnt_inc  = rsp_cnt_q + CNT_ONE;
  assign rsp_part_inc = rsp_part_q + PART_ONE;

  always_comb begin
    state_d    = state_q;
    cin_d      = cin_q;
    base_d     = base_q;
    req_cnt_d  = req_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;
    req_part_d = req_part_q;
    rsp_part_d = rsp_part_q;
    out_d      = out_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    case ({req_hs, rsp_acc})
      2'b10:   out_d = out_q + OUT_ONE;
      2'b01:   out_d = out_q - OUT_ONE;
      default: out_d = out_q;
    endcase

    if (req_hs) begin
      req_cnt_d  = req_cnt_q + CNT_ONE;
      req_part_d = req_part_q + PART_ONE;
    end

    if (rsp_acc) begin
      we_d       = 1'b1;
      waddr_d    = rsp_part_q[BUF_AW-1:0];
      wdata_d    = bus.mem_rsp_data;
      rsp_cnt_d  = rsp_cnt_inc;
      rsp_part_d = rsp_part_inc;
    end

    case (state_q)
      S_IDLE: begin
        if (fc_lif_start) begin
          cin_d      = fc_cin;
          base_d     = base_addr;
          req_cnt_d  = '0;
          rsp_cnt_d  = '0;
          req_part_d = '0;
          rsp_part_d = '0;
          state_d    = (fc_cin == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Completion takes priority, so a final full partition never stalls.
        if (rsp_acc) begin
          if (rsp_cnt_inc == cin_q) begin
            state_d = S_DONE;
          end else if (rsp_part_inc == DEPTH_C) begin
            state_d    = S_PART_WAIT;
            req_part_d = '0;
            rsp_part_d = '0;
          end
        end
      end
      S_PART_WAIT: begin
        if (part_ack) begin
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!fc_lif_start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= S_IDLE;
      cin_q      <= '0;
      base_q     <= '0;
      req_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      req_part_q <= '0;
      rsp_part_q <= '0;
      out_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cin_q      <= cin_d;
      base_q     <= base_d;
      req_cnt_q  <= req_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      req_part_q <= req_part_d;
      rsp_part_q <= rsp_part_d;
      out_q      <= out_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign fc_done           = (state_q == S_DONE);
  assign fc_next_partition = (state_q == S_PART_WAIT);
  assign busy              = (state_q != S_IDLE);

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = req_valid ? wrapAddr(base_q, req_cnt_q) : '0;
  assign bus.buf_we        = we_q;
  assign bus.buf_waddr     = waddr_q;
  assign bus.buf_wdata     = wdata_q;

endmodule

// File: tb/tb_fc_input_loader.sv
// Self-checking bench for fc_input_loader: random memory timing and consumer
// acks, checked against a per-load list of expected addresses and writes.
module tb_fc_input_loader;

  localparam int DW        = 32;
  localparam int BUF_DEPTH = 16;
  localparam int BUF_AW    = 4;
  localparam int MAX_OUT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fcRst;
  logic        start;
  logic        partAck;
  logic [11:0] cin;
  logic [26:0] baseAddr;
  logic        fcDone;
  logic        nextPart;
  logic        busy;

  fc_input_loader_if #(.DW(DW), .BUF_AW(BUF_AW)) bus ();

  fc_input_loader #(
    .DW(DW), .BUF_DEPTH(BUF_DEPTH), .BUF_AW(BUF_AW), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst), .fc_rst(fcRst), .fc_lif_start(start),
    .fc_cin(cin), .base_addr(baseAddr), .fc_done(fcDone),
    .fc_next_partition(nextPart), .part_ack(partAck), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int readyPct   = 100;
  int lat        = 3;
  bit memOn      = 1'b1;
  bit strayOnce  = 1'b0;

  logic [26:0] reqLog[$];
  logic [26:0] pendAddr[$];
  int          pendDue[$];
  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];

  int doneCnt, doneNoWe, npRise, stallViol, stabViol, tbOut, maxOut, ackDelay;
  bit npPrev, prevValid, prevReady;
  logic [26:0] prevAddr;

  // Content of external memory at a word address.
  function automatic logic [31:0] memWord(input logic [26:0] a);
    return {a[15:0], a[26:11]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearLogs();
    reqLog.delete();
    wrAddr.delete();
    wrData.delete();
    doneCnt = 0; doneNoWe = 0; npRise = 0; stallViol = 0; stabViol = 0; maxOut = 0;
    ackDelay = 0;
  endtask

  // One clock: observe what the last edge produced, then drive the memory
  // and consumer inputs that the next edge will sample.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.buf_we) begin
      wrAddr.push_back(32'(bus.buf_waddr));
      wrData.push_back(bus.buf_wdata);
    end
    if (fcDone) begin
      doneCnt++;
      if (!bus.buf_we) doneNoWe++;
    end
    if (nextPart && !npPrev) npRise++;
    npPrev = nextPart;
    if (nextPart && bus.mem_req_valid) stallViol++;
    if (prevValid && !prevReady && (!bus.mem_req_valid || bus.mem_req_addr !== prevAddr))
      stabViol++;

    bus.mem_req_ready = memOn && ($urandom_range(99) < readyPct);
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      reqLog.push_back(bus.mem_req_addr);
      pendAddr.push_back(bus.mem_req_addr);
      pendDue.push_back(cyc + lat);
      tbOut++;
    end
    bus.mem_rsp_valid = 1'b0;
    if (strayOnce) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hDEAD_BEEF;
      strayOnce = 1'b0;
    end else if (memOn && pendAddr.size() > 0 && pendDue[0] <= cyc) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = memWord(pendAddr.pop_front());
      void'(pendDue.pop_front());
      tbOut--;
    end
    if (tbOut > maxOut) maxOut = tbOut;

    partAck = 1'b0;
    if (nextPart) begin
      if (ackDelay == 0) begin
        partAck  = 1'b1;
        ackDelay = $urandom_range(3);
      end else begin
        ackDelay--;
      end
    end

    prevValid = bus.mem_req_valid;
    prevReady = bus.mem_req_ready;
    prevAddr  = bus.mem_req_addr;
  endtask

  task automatic applyStimulus(input int c, input logic [26:0] b, input int rp,
                               input int l, input bit dropEarly);
    int n;
    int expNp;
    int lim;
    logic [26:0] expA;
    readyPct = rp;
    lat      = l;
    clearLogs();
    cin      = 12'(c);
    baseAddr = b;
    start    = 1'b1;
    tick();
    if (c == 0) begin
      checkOutput("cin0_done_at_T1", 32'(fcDone), 32'd1);
      checkOutput("cin0_no_req", 32'(bus.mem_req_valid), 32'd0);
    end else begin
      checkOutput("req_valid_at_T1", 32'(bus.mem_req_valid), 32'd1);
    end
    n = 0;
    while (doneCnt == 0 && n < 5000) begin
      if (dropEarly && n == 4) start = 1'b0;
      tick();
      n++;
    end
    checkOutput("done_within_budget", 32'(doneCnt != 0), 32'd1);
    if (!dropEarly) begin
      repeat (3) tick();
      checkOutput("release_holds_busy", 32'(busy), 32'd1);
    end
    start = 1'b0;
    tick();
    tick();
    checkOutput("idle_after_release", 32'(busy), 32'd0);
    checkOutput("done_pulse_count", 32'(doneCnt), 32'd1);
    if (c > 0) checkOutput("done_with_last_write", 32'(doneNoWe), 32'd0);
    checkOutput("write_count", 32'(wrAddr.size()), 32'(c));
    checkOutput("req_count", 32'(reqLog.size()), 32'(c));
    lim = (reqLog.size() < c) ? reqLog.size() : c;
    for (int k = 0; k < lim; k++) begin
      expA = 27'(longint'(b) + longint'(k));
      checkOutput("req_addr", 32'(reqLog[k]), 32'(expA));
    end
    lim = (wrAddr.size() < c) ? wrAddr.size() : c;
    for (int k = 0; k < lim; k++) begin
      expA = 27'(longint'(b) + longint'(k));
      checkOutput("buf_waddr", wrAddr[k], 32'(k % BUF_DEPTH));
      checkOutput("buf_wdata", wrData[k], memWord(expA));
    end
    expNp = (c == 0) ? 0 : (c - 1) / BUF_DEPTH;
    checkOutput("next_partition_count", 32'(npRise), 32'(expNp));
    checkOutput("outstanding_bound", 32'(maxOut <= MAX_OUT), 32'd1);
    checkOutput("addr_stable_while_stalled", 32'(stabViol), 32'd0);
    checkOutput("no_req_during_part_wait", 32'(stallViol), 32'd0);
    checkOutput("all_rsp_consumed", 32'(pendAddr.size()), 32'd0);
  endtask

  task automatic abortLoad(input bit useFcRst);
    int n;
    clearLogs();
    readyPct = 100;
    lat      = 4;
    cin      = 12'd8;
    baseAddr = 27'h0002000;
    start    = 1'b1;
    tick();
    n = 0;
    while (wrAddr.size() < 3 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("abort_after_three", 32'(wrAddr.size()), 32'd3);
    if (useFcRst) fcRst = 1'b1; else rst = 1'b1;
    start = 1'b0;
    memOn = 1'b0;
    pendAddr.delete();
    pendDue.delete();
    tbOut     = 0;
    prevValid = 1'b0;
    tick();
    checkOutput("abort_done", 32'(fcDone), 32'd0);
    checkOutput("abort_next_part", 32'(nextPart), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_req_valid", 32'(bus.mem_req_valid), 32'd0);
    checkOutput("abort_req_addr", 32'(bus.mem_req_addr), 32'd0);
    checkOutput("abort_buf_we", 32'(bus.buf_we), 32'd0);
    checkOutput("abort_buf_waddr", 32'(bus.buf_waddr), 32'd0);
    checkOutput("abort_buf_wdata", bus.buf_wdata, 32'd0);
    rst       = 1'b0;
    fcRst     = 1'b0;
    strayOnce = 1'b1;
    repeat (3) tick();
    memOn = 1'b1;
    checkOutput("stray_rsp_no_write", 32'(wrAddr.size()), 32'd3);
    checkOutput("stray_rsp_stays_idle", 32'(busy), 32'd0);
    checkOutput("aborted_no_done", 32'(doneCnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1; fcRst = 1'b0; start = 1'b0; partAck = 1'b0;
    cin = '0; baseAddr = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    tbOut = 0; npPrev = 1'b0; prevValid = 1'b0; prevReady = 1'b0; prevAddr = '0;
    clearLogs();
    tick();
    tick();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(fcDone), 32'd0);
    checkOutput("reset_next_part", 32'(nextPart), 32'd0);
    checkOutput("reset_req_valid", 32'(bus.mem_req_valid), 32'd0);
    checkOutput("reset_buf_we", 32'(bus.buf_we), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] basic load of 5 words");
    applyStimulus(5, 27'h0000100, 100, 3, 1'b0);
    $display("[TB] empty load");
    applyStimulus(0, 27'h0000400, 100, 3, 1'b0);
    $display("[TB] partitioned loads");
    applyStimulus(40, 27'(($urandom % 32'h0100_0000)), 100, 3, 1'b0);
    applyStimulus(32, 27'h0001000, 100, 3, 1'b0);
    $display("[TB] slow memory, 30 percent ready");
    applyStimulus(40, 27'h0003000, 30, 10, 1'b0);
    $display("[TB] address wrap");
    applyStimulus(4, 27'h7FFFFFE, 100, 3, 1'b0);
    $display("[TB] abort and restart");
    abortLoad(1'b0);
    applyStimulus(2, 27'h0005000, 100, 3, 1'b0);
    abortLoad(1'b1);
    applyStimulus(2, 27'h7FFFFFF, 70, 2, 1'b0);
    $display("[TB] random loads");
    for (int t = 0; t < 5; t++) begin
      applyStimulus(int'($urandom_range(70, 1)), 27'($urandom),
                    int'($urandom_range(100, 20)), int'($urandom_range(8, 1)),
                    1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
